ex_muldiv: RTL and testbench

- Iterative multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register.
- Consumes the forwarded source operands (SrcAE/SrcBE) plus a decoded mul/div opcode, and owns the architectural HI/LO registers.
- Asserts busy so the hazard unit stalls dependent MFHI/MFLO and later mul/div/MTHI/MTLO instructions.

---
 rtl/ex_muldiv.sv | 160 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative radix-2 multiply/divide unit for the execute stage; owns the HI/LO registers.
// One operation in flight at a time: IDLE accepts, RUN iterates WIDTH times, FIX signs and writes back.
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic               is_div_q, is_div_d, neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d, dz_q, dz_d;

    // Operand magnitudes; unsigned ops (op[0]=0) pass the raw values through.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_neg = op[0] && srca[WIDTH-1];
    assign b_neg = op[0] && srcb[WIDTH-1];
    assign a_mag = a_neg ? -srca : srca;
    assign b_mag = b_neg ? -srcb : srcb;

    // Multiply step: acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide step: acc = {remainder, dividend bits shifting out / quotient bits shifting in}.
    logic [WIDTH:0]     div_trial, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = div_trial - {1'b0, mag_q};
    assign div_ge    = ~div_diff[WIDTH];
    assign div_next  = {div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0],
                        acc_q[WIDTH-2:0], div_ge};

    // Sign correction; a zero divisor forces an all-ones quotient regardless of signs.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quo_fix  = dz_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a latch.
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mag_d     = mag_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start && !clr) begin
                    case (op)
                        3'b100: hi_d = srca;
                        3'b101: lo_d = srca;
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            is_div_d  = op[1];
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            dz_d      = op[1] && (srcb == '0);
                            acc_d     = op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                            mag_d     = op[1] ? b_mag : a_mag;
                            cnt_d     = '0;
                            busy_d    = 1'b1;
                            state_d   = S_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (clr) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = S_FIX;
                end
            end
            S_FIX: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (!clr) begin
                    hi_d   = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                    lo_d   = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
                    done_d = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: datapath registers are reset too, so a reset mid-operation leaves no stale state behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mag_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mag_q     <= mag_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv: inputs driven and outputs sampled on the falling edge.
module tb_ex_muldiv;
    localparam int W = 32;
    localparam logic [2:0] OP_MULTU = 3'b000, OP_MULT = 3'b001, OP_DIVU = 3'b010,
                           OP_DIV = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101;

    logic         clk = 1'b0, rst = 1'b1, clr = 1'b0, start = 1'b0;
    logic [2:0]   op = 3'b110;
    logic [W-1:0] srca = '0, srcb = '0;
    logic [W-1:0] hi, lo;
    logic         busy, done;
    int           errors = 0, checks = 0;

    ex_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .clr(clr), .start(start), .op(op),
        .srca(srca), .srcb(srcb), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Presents one op for exactly one rising edge; returns on the falling edge after it.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; op = o; srca = a; srcb = b;
        @(negedge clk);
        start = 1'b0; op = 3'b110;
    endtask

    // Counts busy cycles until done is seen, bounded to 100 cycles.
    task automatic wait_done(output int bc, output bit got);
        bc = 0; got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            if (done) got = 1'b1;
            else begin
                if (busy) bc++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (hi !== '0)   begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== '0)   begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
        checks++; if (busy !== 0)  begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 0)  begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        rst = 1'b0;
    endtask

    task automatic test_multu;
        int bc; bit got;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(bc, got);
        checks++; if (!got)     begin errors++; $display("FAIL multu_done got=0 exp=1"); end
        checks++; if (bc != 33) begin errors++; $display("FAIL multu_busy_cycles got=%0d exp=33", bc); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
        checks++; if (busy !== 0) begin errors++; $display("FAIL multu_busy_at_done got=%b exp=0", busy); end
        @(negedge clk);
        checks++; if (done !== 0) begin errors++; $display("FAIL multu_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_signed;
        int bc; bit got;
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done(bc, got);
        checks++; if (!got) begin errors++; $display("FAIL mult_done got=0 exp=1"); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo got=%h exp=ffffffeb", lo); end
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(bc, got);
        checks++; if (bc != 33) begin errors++; $display("FAIL div_busy_cycles got=%0d exp=33", bc); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
    endtask

    task automatic test_div_edge;
        int bc; bit got;
        issue(OP_DIVU, 32'd100, 32'd0);
        wait_done(bc, got);
        checks++; if (bc != 33) begin errors++; $display("FAIL divzero_busy_cycles got=%0d exp=33", bc); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divzero_lo got=%h exp=ffffffff", lo); end
        checks++; if (hi !== 32'd100) begin errors++; $display("FAIL divzero_hi got=%h exp=00000064", hi); end
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd0);
        wait_done(bc, got);
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sdivzero_lo got=%h exp=ffffffff", lo); end
        checks++; if (hi !== 32'hFFFF_FFF9) begin errors++; $display("FAIL sdivzero_hi got=%h exp=fffffff9", hi); end
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(bc, got);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo got=%h exp=80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL divovf_hi got=%h exp=00000000", hi); end
    endtask

    task automatic test_mthi_mtlo;
        @(negedge clk);
        start = 1'b1; op = OP_MTHI; srca = 32'h1234;
        @(negedge clk);
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi_hi got=%h exp=00001234", hi); end
        checks++; if (busy !== 0) begin errors++; $display("FAIL mthi_busy got=%b exp=0", busy); end
        op = OP_MTLO; srca = 32'h5678;
        @(negedge clk);
        start = 1'b0; op = 3'b110;
        checks++; if (lo !== 32'h5678) begin errors++; $display("FAIL mtlo_lo got=%h exp=00005678", lo); end
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mtlo_hi_hold got=%h exp=00001234", hi); end
        checks++; if (busy !== 0 || done !== 0) begin errors++; $display("FAIL mtlo_busy_done got=%b%b exp=00", busy, done); end
        // Reserved opcode must leave everything alone.
        issue(3'b111, 32'hAAAA_AAAA, 32'h1);
        checks++; if (hi !== 32'h1234 || lo !== 32'h5678 || busy !== 0) begin
            errors++; $display("FAIL noop got=%h/%h/%b exp=00001234/00005678/0", hi, lo, busy); end
    endtask

    task automatic test_back_to_back;
        int bc; bit got;
        issue(OP_DIVU, 32'd50, 32'd7);
        repeat (3) @(negedge clk);
        start = 1'b1; op = OP_DIV; srca = 32'hFFFF_FF9C; srcb = 32'd3;
        @(negedge clk);
        start = 1'b0; op = 3'b110;
        wait_done(bc, got);
        checks++; if (!got) begin errors++; $display("FAIL b2b_done got=0 exp=1"); end
        checks++; if (lo !== 32'd7) begin errors++; $display("FAIL b2b_lo got=%h exp=00000007", lo); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL b2b_hi got=%h exp=00000001", hi); end
        @(negedge clk);
        checks++; if (busy !== 0) begin errors++; $display("FAIL b2b_no_queue got=%b exp=0", busy); end
    endtask

    task automatic test_clr;
        int seen;
        issue(OP_DIVU, 32'd50, 32'd7);
        repeat (8) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++; if (busy !== 0 || done !== 0) begin errors++; $display("FAIL clr_busy_done got=%b%b exp=00", busy, done); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL clr_quiet got=%0d exp=0", seen); end
        checks++; if (hi !== 32'd1 || lo !== 32'd7) begin errors++; $display("FAIL clr_hold got=%h/%h exp=00000001/00000007", hi, lo); end
        clr = 1'b1; start = 1'b1; op = OP_MTHI; srca = 32'hDEAD;
        @(negedge clk);
        op = OP_MULTU; srca = 32'd3; srcb = 32'd5;
        @(negedge clk);
        clr = 1'b0; start = 1'b0; op = 3'b110;
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL clr_mthi got=%h exp=00000001", hi); end
        checks++; if (busy !== 0) begin errors++; $display("FAIL clr_start_busy got=%b exp=0", busy); end
    endtask

    task automatic test_async_reset;
        int bc; bit got;
        issue(OP_MULTU, 32'h0000_FFFF, 32'h0000_FFFF);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (hi !== '0 || lo !== '0) begin errors++; $display("FAIL arst_hilo got=%h/%h exp=0/0", hi, lo); end
        checks++; if (busy !== 0) begin errors++; $display("FAIL arst_busy got=%b exp=0", busy); end
        @(negedge clk);
        rst = 1'b0;
        issue(OP_MULTU, 32'd6, 32'd7);
        wait_done(bc, got);
        checks++; if (!got) begin errors++; $display("FAIL arst_mul_done got=0 exp=1"); end
        checks++; if (lo !== 32'd42 || hi !== '0) begin errors++; $display("FAIL arst_mul got=%h/%h exp=00000000/0000002a", hi, lo); end
    endtask

    initial begin
        test_reset;
        test_multu;
        test_signed;
        test_div_edge;
        test_mthi_mtlo;
        test_back_to_back;
        test_clr;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
